// File: rtl/nn_acc_sequencer_if.sv
// Operand stream, result stream and Avalon-MM burst master bundle for nn_acc_sequencer.
// The master modport is the sequencer's view; the slave modport is the accelerator/environment view.
`timescale 1ns/1ps
interface nn_acc_sequencer_if;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic [7:0]  acc_address;
  logic        acc_read;
  logic        acc_write;
  logic        acc_beginbursttransfer;
  logic [10:0] acc_burstcount;
  logic [31:0] acc_writedata;
  logic        acc_waitrequest;
  logic        acc_readdatavalid;
  logic [31:0] acc_readdata;

  modport master (
    input  src_valid, src_data, acc_waitrequest, acc_readdatavalid, acc_readdata,
    output src_ready, res_valid, res_data, acc_address, acc_read, acc_write,
           acc_beginbursttransfer, acc_burstcount, acc_writedata
  );

  modport slave (
    output src_valid, src_data, acc_waitrequest, acc_readdatavalid, acc_readdata,
    input  src_ready, res_valid, res_data, acc_address, acc_read, acc_write,
           acc_beginbursttransfer, acc_burstcount, acc_writedata
  );
endinterface

// File: rtl/nn_acc_sequencer.sv
// Avalon-MM burst master that runs one fully-connected layer pass on a single-MAC accelerator:
// per neuron a weight burst and an image burst, a calculation wait, then one result read burst.
`timescale 1ns/1ps
module nn_acc_sequencer #(
  parameter int unsigned VEC_LEN      = 96,
  parameter int unsigned MAX_NEURONS  = 24,
  parameter logic [7:0]  WEIGHT_BASE  = 8'h01,
  parameter logic [7:0]  IMAGE_BASE   = 8'h61,
  parameter logic [7:0]  RESULT_BASE  = 8'hC1,
  parameter int unsigned CALC_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         num_neurons,
  output logic               busy,
  output logic               done,
  output logic               error,
  nn_acc_sequencer_if.master bus
);

  localparam int unsigned CALC_W = $clog2(CALC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_BEGIN   = 3'd1,
    W_DATA    = 3'd2,
    I_BEGIN   = 3'd3,
    I_DATA    = 3'd4,
    CALC_WAIT = 3'd5,
    R_BEGIN   = 3'd6,
    R_DATA    = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          n_q, n_d;
  logic [6:0]          word_cnt_q, word_cnt_d;
  logic [4:0]          neuron_cnt_q, neuron_cnt_d;
  logic [4:0]          rd_cnt_q, rd_cnt_d;
  logic [CALC_W-1:0]   calc_cnt_q, calc_cnt_d;
  logic                seen_wait_q, seen_wait_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                res_valid_q, res_valid_d;
  logic [31:0]         res_data_q, res_data_d;
  logic [7:0]          acc_address_q, acc_address_d;
  logic [10:0]         acc_burstcount_q, acc_burstcount_d;
  logic                acc_begin_q, acc_begin_d;
  logic                acc_read_q, acc_read_d;

  logic                data_phase;
  logic                word_accept;

  // Write-data path is a direct pass-through of the operand stream while a burst is open.
  assign data_phase  = (state_q == W_DATA) || (state_q == I_DATA);
  assign word_accept = data_phase && bus.src_valid && !bus.acc_waitrequest;

  assign bus.src_ready              = data_phase && !bus.acc_waitrequest;
  assign bus.acc_write              = data_phase && bus.src_valid;
  assign bus.acc_writedata          = data_phase ? bus.src_data : 32'h0000_0000;
  assign bus.acc_address            = acc_address_q;
  assign bus.acc_burstcount         = acc_burstcount_q;
  assign bus.acc_beginbursttransfer = acc_begin_q;
  assign bus.acc_read               = acc_read_q;
  assign bus.res_valid              = res_valid_q;
  assign bus.res_data               = res_data_q;
  assign busy                       = busy_q;
  assign done                       = done_q;
  assign error                      = error_q;

  // State register and all sequencer flops; reset aborts a pass silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      n_q              <= 5'd0;
      word_cnt_q       <= 7'd0;
      neuron_cnt_q     <= 5'd0;
      rd_cnt_q         <= 5'd0;
      calc_cnt_q       <= '0;
      seen_wait_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      res_valid_q      <= 1'b0;
      res_data_q       <= 32'h0000_0000;
      acc_address_q    <= 8'h00;
      acc_burstcount_q <= 11'd0;
      acc_begin_q      <= 1'b0;
      acc_read_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      n_q              <= n_d;
      word_cnt_q       <= word_cnt_d;
      neuron_cnt_q     <= neuron_cnt_d;
      rd_cnt_q         <= rd_cnt_d;
      calc_cnt_q       <= calc_cnt_d;
      seen_wait_q      <= seen_wait_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      error_q          <= error_d;
      res_valid_q      <= res_valid_d;
      res_data_q       <= res_data_d;
      acc_address_q    <= acc_address_d;
      acc_burstcount_q <= acc_burstcount_d;
      acc_begin_q      <= acc_begin_d;
      acc_read_q       <= acc_read_d;
    end
  end

  // Next-state, counter and status-pulse logic.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    neuron_cnt_d = neuron_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    calc_cnt_d   = calc_cnt_q;
    seen_wait_d  = seen_wait_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((num_neurons != 5'd0) && (num_neurons <= 5'(MAX_NEURONS))) begin
            n_d          = num_neurons;
            busy_d       = 1'b1;
            word_cnt_d   = 7'd0;
            neuron_cnt_d = 5'd0;
            rd_cnt_d     = 5'd0;
            state_d      = W_BEGIN;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      W_BEGIN: state_d = W_DATA;
      W_DATA, I_DATA: begin
        if (word_accept) begin
          if (word_cnt_q == 7'(VEC_LEN - 1)) begin
            word_cnt_d  = 7'd0;
            calc_cnt_d  = '0;
            seen_wait_d = 1'b0;
            state_d     = (state_q == W_DATA) ? I_BEGIN : CALC_WAIT;
          end else begin
            word_cnt_d = word_cnt_q + 7'd1;
          end
        end else begin
          word_cnt_d = word_cnt_q;
        end
      end
      I_BEGIN: state_d = I_DATA;
      // Completion is a stall that has been seen to start and then to end.
      CALC_WAIT: begin
        if (seen_wait_q && !bus.acc_waitrequest) begin
          neuron_cnt_d = neuron_cnt_q + 5'd1;
          state_d      = (neuron_cnt_q < (n_q - 5'd1)) ? W_BEGIN : R_BEGIN;
        end else if (calc_cnt_q == CALC_W'(CALC_TIMEOUT)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          calc_cnt_d = calc_cnt_q + {{(CALC_W-1){1'b0}}, 1'b1};
          if (bus.acc_waitrequest) begin
            seen_wait_d = 1'b1;
          end else begin
            seen_wait_d = seen_wait_q;
          end
        end
      end
      R_BEGIN: state_d = R_DATA;
      R_DATA: begin
        if (bus.acc_readdatavalid) begin
          res_valid_d = 1'b1;
          res_data_d  = bus.acc_readdata;
          if (rd_cnt_q == (n_q - 5'd1)) begin
            rd_cnt_d = 5'd0;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + 5'd1;
          end
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus request outputs are decoded from the next state so they leave a flop.
  always_comb begin
    acc_address_d    = 8'h00;
    acc_burstcount_d = 11'd0;
    acc_begin_d      = 1'b0;
    acc_read_d       = 1'b0;
    case (state_d)
      W_BEGIN, W_DATA: begin
        acc_address_d    = WEIGHT_BASE;
        acc_burstcount_d = 11'(VEC_LEN);
        acc_begin_d      = (state_d == W_BEGIN);
      end
      I_BEGIN, I_DATA: begin
        acc_address_d    = IMAGE_BASE;
        acc_burstcount_d = 11'(VEC_LEN);
        acc_begin_d      = (state_d == I_BEGIN);
      end
      R_BEGIN, R_DATA: begin
        acc_address_d    = RESULT_BASE;
        acc_burstcount_d = {6'd0, n_d};
        acc_begin_d      = (state_d == R_BEGIN);
        acc_read_d       = 1'b1;
      end
      default: acc_address_d = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_nn_acc_sequencer.sv
// Self-checking bench for nn_acc_sequencer: a behavioural accelerator stub computes dot products
// from the words it actually receives, and an independent model predicts results and burst headers.
`timescale 1ns/1ps
module tb_nn_acc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] num_neurons;
  logic       busy, done, error;

  nn_acc_sequencer_if bus ();

  nn_acc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_neurons (num_neurons),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned  src_q[$];
  logic [31:0]  wbuf[$], ibuf[$], res_mem[$], exp_res[$], got_q[$];
  logic [18:0]  exp_begin_q[$];
  int  rd_idx = 0, calc_left = 0, src_mode = 0, cyc = 0, viol = 0;
  int  done_cnt = 0, err_cnt = 0, reset_at_img = 0;
  int  calc_entry_cyc = 0, err_cyc = 0;
  bit  calc_active = 1'b0, timeout_mode = 1'b0, in_data = 1'b0;
  bit  start_pending = 1'b0, reset_pending = 1'b0;
  logic done_rv, busy_at_done, busy_at_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] int_to_f32(input int unsigned v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (v[i]) p = i;
    m = (p <= 23) ? (v << (23 - p)) : (v >> (p - 23));
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int unsigned f32_to_int(input logic [31:0] f);
    int e;
    logic [31:0] m;
    e = int'(f[30:23]) - 127;
    if (f[30:23] == 8'd0 || e < 0) return 0;
    m = {8'h00, 1'b1, f[22:0]};
    return (e <= 23) ? (m >> (23 - e)) : (m << (e - 23));
  endfunction

  // Model: operand stream and expected results/bursts for a pass.
  task automatic gen_pass(input int n, input bit pattern);
    int unsigned w[96], x[96], sum;
    for (int k = 0; k < n; k++) begin
      sum = 0;
      for (int j = 0; j < 96; j++) begin
        w[j] = pattern ? 1 : $urandom_range(0, 15);
        x[j] = pattern ? k + 1 : $urandom_range(0, 15);
        sum += w[j] * x[j];
      end
      for (int j = 0; j < 96; j++) src_q.push_back(int_to_f32(w[j]));
      for (int j = 0; j < 96; j++) src_q.push_back(int_to_f32(x[j]));
      exp_res.push_back(int_to_f32(sum));
      exp_begin_q.push_back({8'h01, 11'd96});
      exp_begin_q.push_back({8'h61, 11'd96});
    end
    exp_begin_q.push_back({8'hC1, 11'(n)});
  endtask

  task automatic step();
    logic [18:0] e;
    logic wx, acc, was_begin;
    int unsigned sum;
    @(posedge clk); #1;
    reset = reset_pending; reset_pending = 1'b0;
    start = start_pending; start_pending = 1'b0;
    if (bus.acc_beginbursttransfer) bus.acc_waitrequest = 1'b1;
    else if (calc_active) begin
      if (calc_left > 0) begin bus.acc_waitrequest = 1'b1; calc_left--; end
      else begin bus.acc_waitrequest = 1'b0; calc_active = 1'b0; end
    end
    else if (src_mode != 0) bus.acc_waitrequest = ($urandom_range(0, 3) == 0);
    else bus.acc_waitrequest = 1'b0;
    bus.acc_readdatavalid = 1'b0;
    bus.acc_readdata = $urandom;
    if (bus.acc_read && !bus.acc_beginbursttransfer && rd_idx < res_mem.size() &&
        (src_mode == 0 || $urandom_range(0, 2) != 0)) begin
      bus.acc_readdatavalid = 1'b1;
      bus.acc_readdata = res_mem[rd_idx];
      rd_idx++;
    end
    case (src_mode)
      0:       bus.src_valid = (src_q.size() > 0);
      1:       bus.src_valid = (src_q.size() > 0) && cyc[0];
      default: bus.src_valid = (src_q.size() > 0) && ($urandom_range(0, 1) == 1);
    endcase
    bus.src_data = bus.src_valid ? src_q[0] : $urandom;
    @(negedge clk);
    wx  = bus.acc_write && !bus.acc_waitrequest;
    acc = bus.src_valid && bus.src_ready;
    if (wx !== acc) viol++;
    if (bus.acc_write !== (in_data && bus.src_valid)) viol++;
    if (bus.src_ready !== (in_data && !bus.acc_waitrequest)) viol++;
    if (bus.acc_write && bus.acc_writedata !== bus.src_data) viol++;
    if (acc && src_q.size() > 0) void'(src_q.pop_front());
    if (wx) begin
      if (!in_data) viol++;
      if (bus.acc_address == 8'h01) begin
        wbuf.push_back(bus.acc_writedata);
        if (wbuf.size() == 96) in_data = 1'b0;
      end else if (bus.acc_address == 8'h61) begin
        ibuf.push_back(bus.acc_writedata);
        if (reset_at_img != 0 && ibuf.size() == reset_at_img) begin
          reset_pending = 1'b1; reset_at_img = 0;
        end
        if (ibuf.size() == 96) begin
          sum = 0;
          for (int j = 0; j < 96; j++) sum += f32_to_int(wbuf[j]) * f32_to_int(ibuf[j]);
          res_mem.push_back(int_to_f32(sum));
          wbuf.delete(); ibuf.delete();
          in_data = 1'b0; calc_active = 1'b1; calc_entry_cyc = cyc;
          calc_left = timeout_mode ? 5000 : $urandom_range(1, 12);
        end
      end else viol++;
    end
    was_begin = bus.acc_beginbursttransfer;
    if (was_begin) begin
      if (exp_begin_q.size() == 0) viol++;
      else begin
        e = exp_begin_q.pop_front();
        chk("burst_addr", 32'(bus.acc_address), 32'(e[18:11]));
        chk("burst_count", 32'(bus.acc_burstcount), 32'(e[10:0]));
        chk("burst_read", 32'(bus.acc_read), 32'(e[18:11] == 8'hC1));
        if (e[18:11] != 8'hC1) in_data = 1'b1;
      end
    end
    if (bus.res_valid) got_q.push_back(bus.res_data);
    if (done) begin done_cnt++; done_rv = bus.res_valid; busy_at_done = busy; end
    if (error) begin err_cnt++; busy_at_err = busy; err_cyc = cyc; end
    cyc++;
  endtask

  task automatic clear_env();
    src_q.delete(); wbuf.delete(); ibuf.delete(); res_mem.delete(); exp_res.delete();
    got_q.delete(); exp_begin_q.delete();
    rd_idx = 0; in_data = 1'b0; calc_active = 1'b0; calc_left = 0;
  endtask

  task automatic begin_pass(input int n, input bit pattern, input int mode);
    clear_env();
    src_mode = mode;
    gen_pass(n, pattern);
    num_neurons = 5'(n);
    start_pending = 1'b1;
    step();
    step();
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_pass(input int n, input bit pattern, input int mode);
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    begin_pass(n, pattern, mode);
    for (int i = 0; i < 20000 && done_cnt == d0 && err_cnt == e0; i++) step();
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
    chk("no_error", 32'(err_cnt - e0), 32'd0);
    chk("done_with_res_valid", 32'(done_rv), 32'd1);
    chk("busy_at_done", 32'(busy_at_done), 32'd0);
    chk("res_count", 32'(got_q.size()), 32'(n));
    for (int k = 0; k < n && k < got_q.size(); k++) chk("res_data", got_q[k], exp_res[k]);
    chk("bursts_issued", 32'(exp_begin_q.size()), 32'd0);
    chk("src_drained", 32'(src_q.size()), 32'd0);
    chk("protocol", 32'(viol), 32'd0);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic bad_start(input logic [4:0] n);
    int e0;
    e0 = err_cnt;
    clear_env();
    num_neurons = n;
    start_pending = 1'b1;
    step();
    step();
    chk("bad_n_error", 32'(error), 32'd1);
    chk("bad_n_busy", 32'(busy), 32'd0);
    step();
    chk("bad_n_error_pulse", 32'(error), 32'd0);
    repeat (5) step();
    chk("bad_n_error_count", 32'(err_cnt - e0), 32'd1);
    chk("bad_n_busy_idle", 32'(busy), 32'd0);
    chk("bad_n_no_bursts", 32'(viol), 32'd0);
  endtask

  initial begin
    int d0, e0, lat;
    reset = 1'b1; start = 1'b0; num_neurons = 5'd0;
    bus.src_valid = 1'b0; bus.src_data = 32'h0; bus.acc_waitrequest = 1'b0;
    bus.acc_readdatavalid = 1'b0; bus.acc_readdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_address", 32'(bus.acc_address), 32'd0);
    chk("rst_burstcount", 32'(bus.acc_burstcount), 32'd0);
    chk("rst_read", 32'(bus.acc_read), 32'd0);
    chk("rst_write", 32'(bus.acc_write), 32'd0);
    chk("rst_begin", 32'(bus.acc_beginbursttransfer), 32'd0);
    chk("rst_src_ready", 32'(bus.src_ready), 32'd0);
    // start together with reset: reset must win
    @(posedge clk); #1 start = 1'b1; num_neurons = 5'd1;
    @(posedge clk); #1 start = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("start_during_reset", 32'(busy), 32'd0);

    run_pass(1, 1'b0, 0);
    run_pass(24, 1'b1, 0);
    run_pass(3, 1'b0, 1);
    run_pass($urandom_range(2, 6), 1'b0, 2);

    bad_start(5'd0);
    bad_start(5'd25);

    // calculation that never finishes
    d0 = done_cnt; e0 = err_cnt;
    timeout_mode = 1'b1;
    begin_pass(1, 1'b0, 0);
    for (int i = 0; i < 3000 && err_cnt == e0; i++) step();
    chk("timeout_error", 32'(err_cnt - e0), 32'd1);
    chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    chk("timeout_busy", 32'(busy_at_err), 32'd0);
    lat = err_cyc - calc_entry_cyc;
    chk("timeout_latency", 32'(lat >= 1024 && lat <= 1030), 32'd1);
    timeout_mode = 1'b0;
    clear_env();
    step();
    chk("timeout_error_pulse", 32'(error), 32'd0);
    repeat (4) step();
    chk("timeout_idle_protocol", 32'(viol), 32'd0);
    run_pass(1, 1'b0, 0);

    // reset in the middle of an image burst
    d0 = done_cnt; e0 = err_cnt;
    reset_at_img = 40;
    begin_pass(2, 1'b0, 0);
    for (int i = 0; i < 2000 && !reset_pending; i++) step();
    chk("reset_reached", 32'(reset_pending), 32'd1);
    step();
    clear_env();
    step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("midrst_res_data", bus.res_data, 32'd0);
    chk("midrst_address", 32'(bus.acc_address), 32'd0);
    chk("midrst_burstcount", 32'(bus.acc_burstcount), 32'd0);
    chk("midrst_begin_read_write", 32'({bus.acc_beginbursttransfer, bus.acc_read, bus.acc_write}), 32'd0);
    repeat (5) step();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_no_error", 32'(err_cnt - e0), 32'd0);
    chk("midrst_protocol", 32'(viol), 32'd0);
    run_pass(2, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
